// File: rtl/seg7_pkg.sv
// Shared types and constants for the four-digit 7-segment scan controller.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_GAP,
    ST_SHOW
  } scan_state_e;

  localparam logic [1:0] DIG_A     = 2'd0;
  localparam logic [1:0] DIG_B     = 2'd1;
  localparam logic [1:0] DIG_TENS  = 2'd2;
  localparam logic [1:0] DIG_UNITS = 2'd3;

  // Active-high glyphs in {g,f,e,d,c,b,a} order for hex digits 0..F.
  localparam logic [6:0] HEX_FONT [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  // Splits 0..31 into {tens, units} with a compare/subtract chain instead of a divider.
  function automatic logic [5:0] split_sum(input logic [4:0] s);
    if (s >= 5'd30)
      return {2'd3, 4'(s - 5'd30)};
    else if (s >= 5'd20)
      return {2'd2, 4'(s - 5'd20)};
    else if (s >= 5'd10)
      return {2'd1, 4'(s - 5'd10)};
    else
      return {2'd0, 4'(s)};
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Operand/tick inputs and display pins of the scan controller, bundled as one bus.
interface seg7_scan_ctrl_if;
  logic       Mo;
  logic [3:0] A;
  logic [3:0] B;
  logic [4:0] Sum;
  logic [6:0] Seg;
  logic       Dp;
  logic [3:0] An;

  modport master (
    output Mo, A, B, Sum,
    input  Seg, Dp, An
  );

  modport slave (
    input  Mo, A, B, Sum,
    output Seg, Dp, An
  );
endinterface

// File: rtl/seg7_font.sv
// Combinational hex-digit to active-high segment lookup.
module seg7_font
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Plain table lookup; blanking and polarity are handled by the caller.
  always_comb begin
    seg = HEX_FONT[digit];
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed display driver: hex A, hex B, decimal Sum (tens, units).
// Operands are snapshotted once per frame; every digit change gets a one-cycle anode gap.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit BLANK_ZERO     = 1'b1
) (
  input  logic             Clk,
  input  logic             Clr,
  seg7_scan_ctrl_if.slave  bus
);

  localparam logic [3:0] AN_XOR  = {4{AN_ACTIVE_LOW}};
  localparam logic [6:0] SEG_XOR = {7{SEG_ACTIVE_LOW}};

  logic        mo_meta;
  logic        mo_sync;
  logic        mo_prev;
  logic        tick;

  scan_state_e state;
  scan_state_e state_next;
  logic [1:0]  idx;
  logic [1:0]  idx_next;
  logic        load_snap;

  logic [3:0]  snap_a;
  logic [3:0]  snap_b;
  logic [4:0]  snap_sum;

  logic [1:0]  tens;
  logic [3:0]  units;
  logic [3:0]  digit;
  logic        blank;
  logic [6:0]  glyph;

  logic [3:0]  an_raw;
  logic [6:0]  seg_raw;

  logic [3:0]  an_q;
  logic [6:0]  seg_q;
  logic        dp_q;

  // Mo comes from a ripple counter: two-flop synchroniser, then a registered rising-edge pulse.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      mo_meta <= 1'b0;
      mo_sync <= 1'b0;
      mo_prev <= 1'b0;
      tick    <= 1'b0;
    end else begin
      mo_meta <= bus.Mo;
      mo_sync <= mo_meta;
      mo_prev <= mo_sync;
      tick    <= mo_sync & ~mo_prev;
    end
  end

  // Scan sequencing: OFF until the first tick, then GAP/SHOW per digit; ticks in GAP are dropped.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    load_snap  = 1'b0;
    case (state)
      ST_OFF: begin
        if (tick) begin
          idx_next   = DIG_A;
          load_snap  = 1'b1;
          state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        state_next = ST_SHOW;
      end
      ST_SHOW: begin
        if (tick) begin
          idx_next   = idx + 2'd1;
          load_snap  = (idx == DIG_UNITS);
          state_next = ST_GAP;
        end
      end
      default: begin
        state_next = ST_OFF;
      end
    endcase
  end

  // State, digit index and the per-frame operand snapshot.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      state    <= ST_OFF;
      idx      <= DIG_A;
      snap_a   <= 4'd0;
      snap_b   <= 4'd0;
      snap_sum <= 5'd0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (load_snap) begin
        snap_a   <= bus.A;
        snap_b   <= bus.B;
        snap_sum <= bus.Sum;
      end
    end
  end

  assign {tens, units} = split_sum(snap_sum);

  // Pick the nibble for the current digit; a zero tens digit may be blanked.
  always_comb begin
    digit = snap_a;
    blank = 1'b0;
    case (idx)
      DIG_A:    digit = snap_a;
      DIG_B:    digit = snap_b;
      DIG_TENS: begin
        digit = {2'b00, tens};
        blank = BLANK_ZERO && (tens == 2'd0);
      end
      default:  digit = units;
    endcase
  end

  seg7_font u_font (
    .digit (digit),
    .seg   (glyph)
  );

  // Active-high view of the pins: segments already valid in GAP, anode only in SHOW.
  always_comb begin
    an_raw  = 4'b0000;
    seg_raw = 7'b0000000;
    case (state)
      ST_GAP: begin
        seg_raw = blank ? 7'b0000000 : glyph;
      end
      ST_SHOW: begin
        an_raw  = 4'b0001 << idx;
        seg_raw = blank ? 7'b0000000 : glyph;
      end
      default: begin
      end
    endcase
  end

  // Pin registers; board polarity is applied only here.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      an_q  <= AN_XOR;
      seg_q <= SEG_XOR;
      dp_q  <= SEG_ACTIVE_LOW;
    end else begin
      an_q  <= an_raw ^ AN_XOR;
      seg_q <= seg_raw ^ SEG_XOR;
      dp_q  <= SEG_ACTIVE_LOW;
    end
  end

  assign bus.An  = an_q;
  assign bus.Seg = seg_q;
  assign bus.Dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: two instances (board polarity and inverted
// polarity) driven identically, checked every cycle against an event-scheduling model.
module tb_seg7_scan_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic       mo;
  logic [3:0] a_val;
  logic [3:0] b_val;
  logic [4:0] sum_val;

  int vectors     = 0;
  int miscompares = 0;
  bit cmp_en      = 1'b0;

  always #5 clk = ~clk;

  seg7_scan_ctrl_if bus0 ();
  seg7_scan_ctrl_if bus1 ();

  assign bus0.Mo  = mo;
  assign bus0.A   = a_val;
  assign bus0.B   = b_val;
  assign bus0.Sum = sum_val;
  assign bus1.Mo  = mo;
  assign bus1.A   = a_val;
  assign bus1.B   = b_val;
  assign bus1.Sum = sum_val;

  seg7_scan_ctrl #(
    .SEG_ACTIVE_LOW (1'b0),
    .AN_ACTIVE_LOW  (1'b1),
    .BLANK_ZERO     (1'b1)
  ) dut0 (
    .Clk (clk),
    .Clr (clr),
    .bus (bus0.slave)
  );

  seg7_scan_ctrl #(
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b0),
    .BLANK_ZERO     (1'b1)
  ) dut1 (
    .Clk (clk),
    .Clr (clr),
    .bus (bus1.slave)
  );

  logic [6:0] font_tab [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  // Expected active-high glyph of digit d given an operand snapshot.
  function automatic logic [6:0] model_glyph(input int d, input logic [3:0] a,
                                             input logic [3:0] b, input logic [4:0] s);
    int tens;
    int units;
    tens  = int'(s) / 10;
    units = int'(s) % 10;
    case (d)
      0:       return font_tab[a];
      1:       return font_tab[b];
      2:       return (tens == 0) ? 7'b0000000 : font_tab[tens];
      default: return font_tab[units];
    endcase
  endfunction

  // Model state: Mo history per edge, scan position, snapshot, and scheduled pin changes.
  int         edge_no = 0;
  bit         m_hist [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
  bit         m_active = 1'b0;
  int         m_digit = 0;
  logic [3:0] m_a = 4'd0;
  logic [3:0] m_b = 4'd0;
  logic [4:0] m_sum = 5'd0;
  int         m_last_tick = -10;
  int         blank_edge = -1;
  logic [6:0] blank_seg = 7'd0;
  int         show_edge = -1;
  logic [3:0] show_an = 4'd0;
  logic [6:0] show_seg = 7'd0;
  logic [3:0] hold_an = 4'd0;
  logic [6:0] hold_seg = 7'd0;

  // A Mo rise sampled at edge k becomes an accepted tick at edge k+3; the pins
  // blank one edge after the tick and show the new digit one edge after that.
  always @(posedge clk) begin : model
    bit         tk;
    logic [6:0] g;
    edge_no = edge_no + 1;
    if (blank_edge == edge_no) begin
      hold_an  = 4'd0;
      hold_seg = blank_seg;
    end
    if (show_edge == edge_no) begin
      hold_an  = show_an;
      hold_seg = show_seg;
    end
    tk = m_hist[2] && !m_hist[3];
    if (clr) begin
      m_hist      = '{1'b0, 1'b0, 1'b0, 1'b0};
      m_active    = 1'b0;
      m_digit     = 0;
      m_a         = 4'd0;
      m_b         = 4'd0;
      m_sum       = 5'd0;
      m_last_tick = -10;
      blank_edge  = -1;
      show_edge   = -1;
      hold_an     = 4'd0;
      hold_seg    = 7'd0;
    end else begin
      if (tk && (edge_no != m_last_tick + 1)) begin
        if (!m_active) begin
          m_active = 1'b1;
          m_digit  = 0;
        end else begin
          m_digit = (m_digit + 1) % 4;
        end
        if (m_digit == 0) begin
          m_a   = a_val;
          m_b   = b_val;
          m_sum = sum_val;
        end
        m_last_tick = edge_no;
        g           = model_glyph(m_digit, m_a, m_b, m_sum);
        blank_edge  = edge_no + 1;
        blank_seg   = g;
        show_edge   = edge_no + 2;
        show_an     = 4'b0001 << m_digit;
        show_seg    = g;
      end
      m_hist[3] = m_hist[2];
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = mo;
    end
  end

  task automatic checkOutput(input string name, input logic [6:0] actual,
                             input logic [6:0] expected);
    vectors = vectors + 1;
    if (actual !== expected) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: got %b, expected %b at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Checks both instances against an active-high expectation, applying each one's polarity.
  task automatic check_both(input string name, input logic [3:0] an_hi, input logic [6:0] seg_hi);
    logic [3:0] an_lo;
    logic [6:0] seg_lo;
    an_lo  = ~an_hi;
    seg_lo = ~seg_hi;
    checkOutput({name, "_an0"},  {3'b000, bus0.An}, {3'b000, an_lo});
    checkOutput({name, "_seg0"}, bus0.Seg, seg_hi);
    checkOutput({name, "_dp0"},  {6'd0, bus0.Dp}, 7'd0);
    checkOutput({name, "_an1"},  {3'b000, bus1.An}, {3'b000, an_hi});
    checkOutput({name, "_seg1"}, bus1.Seg, seg_lo);
    checkOutput({name, "_dp1"},  {6'd0, bus1.Dp}, 7'd1);
  endtask

  // Every cycle after the first reset edge, both instances must match the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check_both("model", hold_an, hold_seg);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic [4:0] s);
    a_val   = a;
    b_val   = b;
    sum_val = s;
  endtask

  // One-cycle Mo pulse, then wait until the new digit is on the anodes.
  task automatic pulse_and_settle();
    mo = 1'b1;
    step(1);
    mo = 1'b0;
    step(5);
  endtask

  initial begin
    clr = 1'b1;
    mo  = 1'b0;
    applyStimulus(4'h0, 4'h0, 5'd0);
    step(1);
    cmp_en = 1'b1;
    step(2);
    clr = 1'b0;
    step(5);
    check_both("reset", 4'b0000, 7'b0000000);

    applyStimulus(4'hC, 4'h5, 5'd17);
    mo = 1'b1;
    step(1);
    mo = 1'b0;
    step(4);
    check_both("gap", 4'b0000, 7'b0111001);
    step(1);
    check_both("first", 4'b0001, 7'b0111001);

    pulse_and_settle();
    check_both("frame_b", 4'b0010, 7'b1101101);
    pulse_and_settle();
    check_both("frame_tens", 4'b0100, 7'b0000110);
    pulse_and_settle();
    check_both("frame_units", 4'b1000, 7'b0000111);
    pulse_and_settle();
    check_both("frame_wrap", 4'b0001, 7'b0111001);

    pulse_and_settle();
    applyStimulus(4'h0, 4'h5, 5'd31);
    pulse_and_settle();
    check_both("stale_tens", 4'b0100, 7'b0000110);
    pulse_and_settle();
    check_both("stale_units", 4'b1000, 7'b0000111);
    pulse_and_settle();
    check_both("new_a", 4'b0001, 7'b0111111);
    pulse_and_settle();
    pulse_and_settle();
    check_both("new_tens", 4'b0100, 7'b1001111);
    pulse_and_settle();
    check_both("new_units", 4'b1000, 7'b0000110);

    applyStimulus(4'h0, 4'h5, 5'd4);
    pulse_and_settle();
    pulse_and_settle();
    pulse_and_settle();
    check_both("blank_tens", 4'b0100, 7'b0000000);

    clr = 1'b1;
    step(1);
    check_both("mid_reset", 4'b0000, 7'b0000000);
    clr = 1'b0;
    pulse_and_settle();
    check_both("restart", 4'b0001, 7'b0111111);

    mo = 1'b1;
    step(50);
    mo = 1'b0;
    step(5);
    check_both("held_mo", 4'b0010, 7'b1101101);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) mo = ~mo;
      if ($urandom_range(0, 9) == 0)
        applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      5'($urandom_range(0, 31)));
      clr = ($urandom_range(0, 299) == 0);
      step(1);
    end
    clr = 1'b0;
    mo  = 1'b0;
    step(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
